// File: rtl/delay_timer_bank.sv
// ---------------------------------------------------------------------------
// delay_timer_bank
//
// This is a multi-channel programmable delay timer for the elevator
// controller. One shared prescaler divides the system clock into a base tick
// and a 50% duty slow square wave. NUM_CH independent channels count down
// whole base ticks. Each channel runs either one-shot or auto-reload.
//
// Parameters
//    PRESCALE   clk cycles per base tick (>= 2)
//    PRE_W      prescaler counter width
//    NUM_CH     number of timer channels (>= 1)
//    CNT_W      width of each channel's load value and counter
//
// Ports
//    clk        system clock, rising edge
//    rst        asynchronous reset, active low
//    en         global enable; low freezes the prescaler and all countdowns
//    start      per-channel start/restart request, sampled every cycle
//    stop       per-channel abort request (wins over start)
//    periodic   per-channel mode: 1 = auto-reload, 0 = one-shot
//    load_val   per-channel delay in base ticks, channel i at [i*CNT_W +: CNT_W]
//    base_tick  one-cycle pulse once every PRESCALE enabled cycles
//    slow_clk   square wave toggling on every base tick
//    busy       channel is counting
//    done       one-cycle pulse when a channel expires
//    remaining  current countdown value per channel
// ---------------------------------------------------------------------------
module delay_timer_bank #(
   parameter int PRESCALE = 100000000,
   parameter int PRE_W    = $clog2(PRESCALE),
   parameter int NUM_CH   = 2,
   parameter int CNT_W    = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [NUM_CH-1:0]       start,
   input  logic [NUM_CH-1:0]       stop,
   input  logic [NUM_CH-1:0]       periodic,
   input  logic [NUM_CH*CNT_W-1:0] load_val,
   output logic                    base_tick,
   output logic                    slow_clk,
   output logic [NUM_CH-1:0]       busy,
   output logic [NUM_CH-1:0]       done,
   output logic [NUM_CH*CNT_W-1:0] remaining
);

   // Catch illegal parameter choices at elaboration time.
   if (PRESCALE < 2) begin : g_bad_prescale
      $error("delay_timer_bank: PRESCALE must be at least 2");
   end
   if (NUM_CH < 1) begin : g_bad_num_ch
      $error("delay_timer_bank: NUM_CH must be at least 1");
   end

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0] pre_cnt_q;
   logic             base_tick_q;
   logic             slow_clk_q;
   logic             tick_evt;

   // The tick event is combinational so that every channel can act on the
   // same edge that raises base_tick; this keeps done aligned with it.
   assign tick_evt = en && (pre_cnt_q == PRE_LAST);

   // Shared prescaler. While en is low the count and the slow clock hold, so
   // resuming continues from where it stopped and no tick is lost or doubled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_cnt_q   <= '0;
         base_tick_q <= 1'b0;
         slow_clk_q  <= 1'b0;
      end else if (tick_evt) begin
         pre_cnt_q   <= '0;
         base_tick_q <= 1'b1;
         slow_clk_q  <= ~slow_clk_q;
      end else if (en) begin
         pre_cnt_q   <= pre_cnt_q + PRE_W'(1);
         base_tick_q <= 1'b0;
      end else begin
         base_tick_q <= 1'b0;
      end
   end

   assign base_tick = base_tick_q;
   assign slow_clk  = slow_clk_q;

   // One independent countdown channel per generate iteration.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      state_e           state_q;
      logic [CNT_W-1:0] rem_q;
      logic             done_q;
      logic [CNT_W-1:0] ldVal;

      assign ldVal = load_val[i*CNT_W +: CNT_W];

      // Channel FSM with priority stop > start > tick. done defaults low
      // every cycle so it can only ever be a single-cycle pulse. A zero load
      // value expires immediately instead of entering RUN, and periodic
      // reload samples load_val afresh so software can retune the period
      // while the channel keeps running.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
         end else begin
            done_q <= 1'b0;
            if (stop[i]) begin
               state_q <= IDLE;
               rem_q   <= '0;
            end else if (start[i]) begin
               if (ldVal != '0) begin
                  state_q <= RUN;
                  rem_q   <= ldVal;
               end else begin
                  state_q <= IDLE;
                  rem_q   <= '0;
                  done_q  <= 1'b1;
               end
            end else if ((state_q == RUN) && tick_evt) begin
               if (rem_q > CNT_W'(1)) begin
                  rem_q <= rem_q - CNT_W'(1);
               end else begin
                  done_q <= 1'b1;
                  if (periodic[i] && (ldVal != '0)) begin
                     rem_q <= ldVal;
                  end else begin
                     state_q <= IDLE;
                     rem_q   <= '0;
                  end
               end
            end
         end
      end

      assign busy[i]                      = (state_q == RUN);
      assign done[i]                      = done_q;
      assign remaining[i*CNT_W +: CNT_W]  = rem_q;
   end

endmodule

// File: tb/tb_delay_timer_bank.sv
// ---------------------------------------------------------------------------
// tb_delay_timer_bank
//
// Self-checking bench for delay_timer_bank with PRESCALE=4, NUM_CH=2 and
// CNT_W=4. A table of per-edge vectors covers the prescaler, a one-shot and a
// periodic channel. Hand-written sequences then cover enable gating, stop and
// start priority, zero and maximum loads, simultaneous expiry and
// asynchronous reset.
// ---------------------------------------------------------------------------
module tb_delay_timer_bank;

   localparam int PRESCALE = 4;
   localparam int NUM_CH   = 2;
   localparam int CNT_W    = 4;

   logic       clk;
   logic       rstN;
   logic       en;
   logic [1:0] start;
   logic [1:0] stop;
   logic [1:0] periodic;
   logic [7:0] loadVal;
   logic       baseTick;
   logic       slowClk;
   logic [1:0] busy;
   logic [1:0] done;
   logic [7:0] remaining;

   int vecCount  = 0;
   int missCount = 0;

   typedef struct {
      logic       en;
      logic [1:0] start;
      logic [1:0] stop;
      logic [1:0] periodic;
      logic [3:0] ld0;
      logic [3:0] ld1;
      logic       expTick;
      logic       expSlow;
      logic [1:0] expBusy;
      logic [1:0] expDone;
      logic [3:0] expRem0;
      logic [3:0] expRem1;
   } vec_t;

   vec_t vecs[$];

   delay_timer_bank #(
      .PRESCALE (PRESCALE),
      .PRE_W    ($clog2(PRESCALE)),
      .NUM_CH   (NUM_CH),
      .CNT_W    (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rstN),
      .en        (en),
      .start     (start),
      .stop      (stop),
      .periodic  (periodic),
      .load_val  (loadVal),
      .base_tick (baseTick),
      .slow_clk  (slowClk),
      .busy      (busy),
      .done      (done),
      .remaining (remaining)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [7:0] act,
                              input logic [7:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic e, input logic [1:0] st,
                                input logic [1:0] sp, input logic [1:0] per,
                                input logic [3:0] l0, input logic [3:0] l1);
      en       = e;
      start    = st;
      stop     = sp;
      periodic = per;
      loadVal  = {l1, l0};
   endtask

   // Advance one rising edge and sample 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulse reset between edges and confirm every output is cleared.
   task automatic doReset(input string tag);
      applyStimulus(1'b1, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput({tag, ".rst.tick"}, {7'd0, baseTick}, 8'd0);
      checkOutput({tag, ".rst.slow"}, {7'd0, slowClk}, 8'd0);
      checkOutput({tag, ".rst.busy"}, {6'd0, busy}, 8'd0);
      checkOutput({tag, ".rst.done"}, {6'd0, done}, 8'd0);
      checkOutput({tag, ".rst.rem"}, remaining, 8'd0);
      @(negedge clk);
      rstN = 1'b1;
   endtask

   task automatic addVec(input logic e, input logic [1:0] st, input logic [1:0] sp,
                         input logic [1:0] per, input logic [3:0] l0,
                         input logic [3:0] l1, input logic t, input logic s,
                         input logic [1:0] b, input logic [1:0] d,
                         input logic [3:0] r0, input logic [3:0] r1);
      vec_t v;
      v.en = e; v.start = st; v.stop = sp; v.periodic = per;
      v.ld0 = l0; v.ld1 = l1;
      v.expTick = t; v.expSlow = s; v.expBusy = b; v.expDone = d;
      v.expRem0 = r0; v.expRem1 = r1;
      vecs.push_back(v);
   endtask

   initial begin
      rstN = 1'b0;
      applyStimulus(1'b0, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0);

      // Edge-by-edge table: ch1 periodic load 2 from edge 1 (retuned to 1
      // from edge 16), ch0 one-shot load 3 from edge 2.
      //      en  start  stop   per    l0 l1   tick slow busy   done   r0 r1
      addVec(1, 2'b10, 2'b00, 2'b10, 3, 2,    0, 0, 2'b10, 2'b00, 0, 2); // 1
      addVec(1, 2'b01, 2'b00, 2'b10, 3, 2,    0, 0, 2'b11, 2'b00, 3, 2); // 2
      addVec(1, 2'b00, 2'b00, 2'b10, 3, 2,    0, 0, 2'b11, 2'b00, 3, 2); // 3
      addVec(1, 2'b00, 2'b00, 2'b10, 3, 2,    1, 1, 2'b11, 2'b00, 2, 1); // 4
      addVec(1, 2'b00, 2'b00, 2'b10, 3, 2,    0, 1, 2'b11, 2'b00, 2, 1); // 5
      addVec(1, 2'b00, 2'b00, 2'b10, 3, 2,    0, 1, 2'b11, 2'b00, 2, 1); // 6
      addVec(1, 2'b00, 2'b00, 2'b10, 3, 2,    0, 1, 2'b11, 2'b00, 2, 1); // 7
      addVec(1, 2'b00, 2'b00, 2'b10, 3, 2,    1, 0, 2'b11, 2'b10, 1, 2); // 8
      addVec(1, 2'b00, 2'b00, 2'b10, 3, 2,    0, 0, 2'b11, 2'b00, 1, 2); // 9
      addVec(1, 2'b00, 2'b00, 2'b10, 3, 2,    0, 0, 2'b11, 2'b00, 1, 2); // 10
      addVec(1, 2'b00, 2'b00, 2'b10, 3, 2,    0, 0, 2'b11, 2'b00, 1, 2); // 11
      addVec(1, 2'b00, 2'b00, 2'b10, 3, 2,    1, 1, 2'b10, 2'b01, 0, 1); // 12
      addVec(1, 2'b00, 2'b00, 2'b10, 3, 2,    0, 1, 2'b10, 2'b00, 0, 1); // 13
      addVec(1, 2'b00, 2'b00, 2'b10, 3, 2,    0, 1, 2'b10, 2'b00, 0, 1); // 14
      addVec(1, 2'b00, 2'b00, 2'b10, 3, 2,    0, 1, 2'b10, 2'b00, 0, 1); // 15
      addVec(1, 2'b00, 2'b00, 2'b10, 3, 1,    1, 0, 2'b10, 2'b10, 0, 1); // 16
      addVec(1, 2'b00, 2'b00, 2'b10, 3, 1,    0, 0, 2'b10, 2'b00, 0, 1); // 17
      addVec(1, 2'b00, 2'b00, 2'b10, 3, 1,    0, 0, 2'b10, 2'b00, 0, 1); // 18
      addVec(1, 2'b00, 2'b00, 2'b10, 3, 1,    0, 0, 2'b10, 2'b00, 0, 1); // 19
      addVec(1, 2'b00, 2'b00, 2'b10, 3, 1,    1, 1, 2'b10, 2'b10, 0, 1); // 20
      addVec(1, 2'b00, 2'b00, 2'b10, 3, 1,    0, 1, 2'b10, 2'b00, 0, 1); // 21
      addVec(1, 2'b00, 2'b00, 2'b10, 3, 1,    0, 1, 2'b10, 2'b00, 0, 1); // 22
      addVec(1, 2'b00, 2'b00, 2'b10, 3, 1,    0, 1, 2'b10, 2'b00, 0, 1); // 23
      addVec(1, 2'b00, 2'b00, 2'b10, 3, 1,    1, 0, 2'b10, 2'b10, 0, 1); // 24
      addVec(1, 2'b00, 2'b00, 2'b10, 3, 1,    0, 0, 2'b10, 2'b00, 0, 1); // 25

      doReset("init");
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].en, vecs[i].start, vecs[i].stop,
                       vecs[i].periodic, vecs[i].ld0, vecs[i].ld1);
         step();
         checkOutput($sformatf("vec%0d.tick", i + 1), {7'd0, baseTick},
                     {7'd0, vecs[i].expTick});
         checkOutput($sformatf("vec%0d.slow", i + 1), {7'd0, slowClk},
                     {7'd0, vecs[i].expSlow});
         checkOutput($sformatf("vec%0d.busy", i + 1), {6'd0, busy},
                     {6'd0, vecs[i].expBusy});
         checkOutput($sformatf("vec%0d.done", i + 1), {6'd0, done},
                     {6'd0, vecs[i].expDone});
         checkOutput($sformatf("vec%0d.rem", i + 1), remaining,
                     {vecs[i].expRem1, vecs[i].expRem0});
      end

      // Enable gating: en low for edges 5..9 pushes the second tick to
      // edge 13; a start during en low is still accepted.
      doReset("en");
      for (int k = 1; k <= 14; k++) begin
         applyStimulus(!(k >= 5 && k <= 9), {1'b0, k == 6}, 2'b00, 2'b00,
                       4'd1, 4'd0);
         step();
         checkOutput($sformatf("en%0d.tick", k), {7'd0, baseTick},
                     {7'd0, (k == 4 || k == 13)});
         checkOutput($sformatf("en%0d.slow", k), {7'd0, slowClk},
                     {7'd0, (k >= 4 && k <= 12)});
         checkOutput($sformatf("en%0d.busy", k), {6'd0, busy},
                     {7'd0, (k >= 6 && k <= 12)});
         checkOutput($sformatf("en%0d.done", k), {6'd0, done},
                     {7'd0, k == 13});
      end

      // Stop and start priority, restart on a tick edge, zero-load start.
      doReset("prio");
      applyStimulus(1, 2'b11, 2'b00, 2'b00, 4'd1, 4'd5); step();        // 1
      checkOutput("prio1.rem", remaining, 8'h51);
      applyStimulus(1, 2'b10, 2'b10, 2'b00, 4'd1, 4'd5); step();        // 2
      checkOutput("prio2.busy", {6'd0, busy}, 8'h01);
      checkOutput("prio2.rem", remaining, 8'h01);
      applyStimulus(1, 2'b00, 2'b00, 2'b00, 4'd1, 4'd5); step();        // 3
      applyStimulus(1, 2'b00, 2'b01, 2'b00, 4'd1, 4'd5); step();        // 4
      checkOutput("prio4.tick", {7'd0, baseTick}, 8'h01);
      checkOutput("prio4.done", {6'd0, done}, 8'h00);
      checkOutput("prio4.busy", {6'd0, busy}, 8'h00);
      checkOutput("prio4.rem", remaining, 8'h00);
      applyStimulus(1, 2'b01, 2'b00, 2'b00, 4'd3, 4'd5); step();        // 5
      checkOutput("prio5.done", {6'd0, done}, 8'h00);
      checkOutput("prio5.rem", remaining, 8'h03);
      applyStimulus(1, 2'b00, 2'b00, 2'b00, 4'd3, 4'd5);
      for (int k = 6; k <= 11; k++) step();
      checkOutput("prio11.rem", remaining, 8'h02);
      applyStimulus(1, 2'b01, 2'b00, 2'b00, 4'd6, 4'd5); step();        // 12
      checkOutput("prio12.tick", {7'd0, baseTick}, 8'h01);
      checkOutput("prio12.rem", remaining, 8'h06);
      checkOutput("prio12.busy", {6'd0, busy}, 8'h01);
      applyStimulus(1, 2'b10, 2'b00, 2'b00, 4'd6, 4'd0); step();        // 13
      checkOutput("prio13.done", {6'd0, done}, 8'h02);
      checkOutput("prio13.busy", {6'd0, busy}, 8'h01);
      checkOutput("prio13.rem", remaining, 8'h06);
      applyStimulus(1, 2'b00, 2'b00, 2'b00, 4'd6, 4'd0); step();        // 14
      checkOutput("prio14.done", {6'd0, done}, 8'h00);
      checkOutput("prio14.busy", {6'd0, busy}, 8'h01);

      // Maximum load on both channels: exactly 15 ticks, joint expiry.
      doReset("max");
      applyStimulus(1, 2'b11, 2'b00, 2'b00, 4'd15, 4'd15); step();
      checkOutput("max1.rem", remaining, 8'hFF);
      applyStimulus(1, 2'b00, 2'b00, 2'b00, 4'd15, 4'd15);
      for (int k = 2; k <= 61; k++) begin
         step();
         checkOutput($sformatf("max%0d.done", k), {6'd0, done},
                     (k == 60) ? 8'h03 : 8'h00);
         checkOutput($sformatf("max%0d.busy", k), {6'd0, busy},
                     (k < 60) ? 8'h03 : 8'h00);
         if (k == 4)  checkOutput("max4.rem", remaining, 8'hEE);
         if (k == 56) checkOutput("max56.rem", remaining, 8'h11);
      end

      // Asynchronous reset mid-countdown, then a fresh prescaler phase.
      doReset("arst");
      applyStimulus(1, 2'b01, 2'b00, 2'b00, 4'd5, 4'd0); step();
      applyStimulus(1, 2'b00, 2'b00, 2'b00, 4'd5, 4'd0);
      for (int k = 2; k <= 4; k++) step();
      checkOutput("arst4.slow", {7'd0, slowClk}, 8'h01);
      checkOutput("arst4.rem", remaining, 8'h04);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("arstmid.tick", {7'd0, baseTick}, 8'h00);
      checkOutput("arstmid.slow", {7'd0, slowClk}, 8'h00);
      checkOutput("arstmid.busy", {6'd0, busy}, 8'h00);
      checkOutput("arstmid.rem", remaining, 8'h00);
      @(negedge clk);
      rstN = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         checkOutput($sformatf("arstpost%0d.tick", k), {7'd0, baseTick},
                     {7'd0, k == 4});
         checkOutput($sformatf("arstpost%0d.done", k), {6'd0, done}, 8'h00);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
